// File: rtl/band_relay_writer.sv
`default_nettype none
// ============================================================================
// Module      : band_relay_writer
// Description : Serialises the requested band/PTT relay word into an external
//               74HC595 chain (sclk/sdo/load). The chain is rewritten only
//               when the request differs from the last settled word. Each
//               write is followed by a relay settle wait. tx_enable is raised
//               only once the settled word has the T/R relay in TX position,
//               and it is dropped immediately when PTT or run goes away.
// Ports       :
//   clock       in   system clock, single domain
//   reset       in   synchronous active-high reset
//   run         in   0 forces the request to band 0 with PTT off
//   band[2:0]   in   band code 0..7
//   ptt         in   push-to-talk request
//   relay_sclk  out  shift clock to the relay chain
//   relay_sdo   out  serial data, MSB first, changes while sclk is low
//   relay_load  out  storage-register latch strobe, active high
//   busy        out  high whenever a write or settle is in progress
//   tx_enable   out  high when the relays are confirmed in TX position
// Revision    : 1.0 - initial release
// ============================================================================
module band_relay_writer #(
  parameter int CLK_DIV       = 8,
  parameter int SETTLE_CYCLES = 122880
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [2:0] band,
  input  logic       ptt,
  output logic       relay_sclk,
  output logic       relay_sdo,
  output logic       relay_load,
  output logic       busy,
  output logic       tx_enable
);

  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_ONE     = DIV_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [3:0]          BIT_LAST    = 4'd15;
  // Not a word any request can produce, so the first request after reset
  // always differs and forces a write.
  localparam logic [15:0]         SENT_RESET  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LOAD   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input capture. run is folded in here so the request is already forced to
  // band 0 / PTT off when the link is not running.
  // --------------------------------------------------------------------------
  logic [2:0] band_q;
  logic       ptt_q;
  logic       req_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      band_q    <= 3'd0;
      ptt_q     <= 1'b0;
      req_valid <= 1'b0;
    end else begin
      band_q    <= run ? band : 3'd0;
      ptt_q     <= run & ptt;
      // The captured inputs are only meaningful from the cycle after reset
      // is released; before that band_q/ptt_q hold reset values.
      req_valid <= 1'b1;
    end
  end

  logic [7:0] band_onehot;

  for (genvar i = 0; i < 8; i++) begin : g_onehot
    assign band_onehot[i] = (band_q == 3'(i));
  end

  logic [15:0] request;
  assign request = {7'b0, ptt_q, band_onehot};

  // --------------------------------------------------------------------------
  // FSM and datapath registers
  // --------------------------------------------------------------------------
  state_t              state,        state_next;
  logic [15:0]         shift_reg,    shift_next;
  logic [15:0]         word_latched, word_next;
  logic [15:0]         sent_word,    sent_next;
  logic [DIV_W-1:0]    div_cnt,      div_next;
  logic [3:0]          bit_cnt,      bit_next;
  logic [SETTLE_W-1:0] settle_cnt,   settle_next;
  logic                sclk_q,       sclk_next;
  logic                load_q,       load_next;
  logic                tx_q,         tx_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      shift_reg    <= 16'd0;
      word_latched <= 16'd0;
      sent_word    <= SENT_RESET;
      div_cnt      <= '0;
      bit_cnt      <= 4'd0;
      settle_cnt   <= '0;
      sclk_q       <= 1'b0;
      load_q       <= 1'b0;
      tx_q         <= 1'b0;
    end else begin
      state        <= state_next;
      shift_reg    <= shift_next;
      word_latched <= word_next;
      sent_word    <= sent_next;
      div_cnt      <= div_next;
      bit_cnt      <= bit_next;
      settle_cnt   <= settle_next;
      sclk_q       <= sclk_next;
      load_q       <= load_next;
      tx_q         <= tx_next;
    end
  end

  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    word_next   = word_latched;
    sent_next   = sent_word;
    div_next    = div_cnt;
    bit_next    = bit_cnt;
    settle_next = settle_cnt;
    sclk_next   = sclk_q;
    load_next   = load_q;
    tx_next     = tx_q;

    case (state)
      IDLE: begin
        if (req_valid && (request != sent_word)) begin
          shift_next = request;
          word_next  = request;
          div_next   = '0;
          bit_next   = 4'd0;
          sclk_next  = 1'b0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        // Each half-period lasts CLK_DIV cycles. The register shifts on the
        // falling transition, so sdo moves only while sclk is low.
        if (div_cnt == DIV_LAST) begin
          div_next  = '0;
          sclk_next = ~sclk_q;
          if (sclk_q) begin
            shift_next = {shift_reg[14:0], 1'b0};
            if (bit_cnt == BIT_LAST) begin
              bit_next   = 4'd0;
              load_next  = 1'b1;
              state_next = LOAD;
            end else begin
              bit_next = bit_cnt + 4'd1;
            end
          end
        end else begin
          div_next = div_cnt + DIV_ONE;
        end
      end

      LOAD: begin
        if (div_cnt == DIV_LAST) begin
          div_next    = '0;
          load_next   = 1'b0;
          settle_next = '0;
          state_next  = SETTLE;
        end else begin
          div_next = div_cnt + DIV_ONE;
        end
      end

      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_next = '0;
          sent_next   = word_latched;
          state_next  = IDLE;
        end else begin
          settle_next = settle_cnt + SETTLE_ONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Dropping keying never waits for the relays; raising it requires the
    // settled word to match the live request with the T/R bit set.
    if (!ptt_q || !run) begin
      tx_next = 1'b0;
    end else if ((state == IDLE) && sent_word[8] && (request == sent_word)) begin
      tx_next = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. shift_reg is fully shifted out (all zero) by the end of SHIFT and
  // is cleared by reset, so its MSB is already zero outside SHIFT.
  // --------------------------------------------------------------------------
  assign relay_sclk = sclk_q;
  assign relay_sdo  = shift_reg[15];
  assign relay_load = load_q;
  assign busy       = (state != IDLE);
  assign tx_enable  = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_band_relay_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_band_relay_writer
// Description : Directed bench for band_relay_writer with CLK_DIV=2 and
//               SETTLE_CYCLES=10. A monitor reassembles each word from the
//               serial link; a vector table plus hand sequences check it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_band_relay_writer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run   = 1'b1;
  logic [2:0] band  = 3'd3;
  logic       ptt   = 1'b0;
  logic       relay_sclk;
  logic       relay_sdo;
  logic       relay_load;
  logic       busy;
  logic       tx_enable;

  int checks = 0;
  int errors = 0;

  band_relay_writer #(
    .CLK_DIV      (2),
    .SETTLE_CYCLES(10)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .band      (band),
    .ptt       (ptt),
    .relay_sclk(relay_sclk),
    .relay_sdo (relay_sdo),
    .relay_load(relay_load),
    .busy      (busy),
    .tx_enable (tx_enable)
  );

  always #5 clock = ~clock;

  // Link monitor: rebuilds each word from sdo at sclk rises and records it
  // when the load strobe rises.
  logic [15:0] cap = 16'd0;
  int          rises = 0;
  logic        sclk_d = 1'b0;
  logic        load_d = 1'b0;
  int          load_run = 0;
  logic [15:0] last_word = 16'd0;
  int          last_rises = 0;
  int          last_load_len = 0;
  int          writes = 0;

  always @(negedge clock) begin
    if (reset) begin
      cap      = 16'd0;
      rises    = 0;
      sclk_d   = 1'b0;
      load_d   = 1'b0;
      load_run = 0;
    end else begin
      if (relay_sclk && !sclk_d) begin
        cap   = {cap[14:0], relay_sdo};
        rises = rises + 1;
      end
      if (relay_load) begin
        if (!load_d) begin
          writes     = writes + 1;
          last_word  = cap;
          last_rises = rises;
          cap        = 16'd0;
          rises      = 0;
          load_run   = 0;
        end
        load_run      = load_run + 1;
        last_load_len = load_run;
      end
      sclk_d = relay_sclk;
      load_d = relay_load;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  // Waits until busy equals level; n returns the number of cycles waited.
  task automatic wait_busy(input logic level, input int limit, input string name, output int n);
    n = 0;
    while (busy !== level && n < limit) begin
      tick(1);
      n++;
    end
    if (busy !== level) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout got busy=%0b expected %0b", name, busy, level);
    end
  endtask

  typedef struct {
    logic        run;
    logic [2:0]  band;
    logic        ptt;
    int          nwrites;
    logic [15:0] word;
    logic        tx;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   w0;
    logic tx_seen;

    vecs[0] = '{1'b0, 3'd6, 1'b1, 1, 16'h0001, 1'b0};
    vecs[1] = '{1'b1, 3'd6, 1'b0, 1, 16'h0040, 1'b0};
    vecs[2] = '{1'b1, 3'd7, 1'b1, 1, 16'h0180, 1'b1};
    vecs[3] = '{1'b1, 3'd0, 1'b1, 1, 16'h0101, 1'b1};
    vecs[4] = '{1'b0, 3'd0, 1'b1, 1, 16'h0001, 1'b0};
    vecs[5] = '{1'b1, 3'd0, 1'b0, 0, 16'h0001, 1'b0};
    vecs[6] = '{1'b1, 3'd4, 1'b0, 1, 16'h0010, 1'b0};
    vecs[7] = '{1'b1, 3'd2, 1'b1, 1, 16'h0104, 1'b1};

    // ---- Reset state, then the initial write of band 3 ----
    tick(5);
    check("reset_outputs", {relay_sclk, relay_sdo, relay_load, busy, tx_enable}, 5'b0);
    reset = 1'b0;
    wait_busy(1'b1, 20, "t1_start", n);
    wait_busy(1'b0, 500, "t1_end", n);
    check("t1_busy_len", n, 76);
    check("t1_tx_idle", tx_enable, 1'b0);
    tick(40);
    check("t1_writes", writes, 1);
    check("t1_word", last_word, 16'h0008);
    check("t1_rises", last_rises, 16);
    check("t1_load_len", last_load_len, 2);
    check("t1_quiet", busy, 1'b0);

    // ---- PTT on: tx_enable held off until the settled word is back in IDLE ----
    w0  = writes;
    ptt = 1'b1;
    wait_busy(1'b1, 20, "t2_start", n);
    tx_seen = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      if (tx_enable) tx_seen = 1'b1;
      tick(1);
      n++;
    end
    check("t2_busy_end", busy, 1'b0);
    check("t2_tx_while_busy", tx_seen, 1'b0);
    check("t2_tx_first_idle", tx_enable, 1'b0);
    tick(1);
    check("t2_tx_rise", tx_enable, 1'b1);
    check("t2_writes", writes - w0, 1);
    check("t2_word", last_word, 16'h0108);

    // ---- PTT off: fast drop, then band change during the rewrite ----
    w0  = writes;
    ptt = 1'b0;
    tick(2);
    check("t3_tx_drop", tx_enable, 1'b0);
    check("t3_no_sclk_yet", rises, 0);
    tick(10);
    check("t4_mid_shift", busy, 1'b1);
    band = 3'd5;
    wait_busy(1'b0, 500, "t4_first_end", n);
    check("t4_first_word", last_word, 16'h0008);
    wait_busy(1'b1, 20, "t4_second_start", n);
    check("t4_gap", n, 1);
    wait_busy(1'b0, 500, "t4_second_end", n);
    tick(5);
    check("t4_writes", writes - w0, 2);
    check("t4_second_word", last_word, 16'h0020);

    // ---- Vector table ----
    for (int i = 0; i < 8; i++) begin
      w0   = writes;
      run  = vecs[i].run;
      band = vecs[i].band;
      ptt  = vecs[i].ptt;
      tick(5);
      wait_busy(1'b0, 500, $sformatf("vec%0d_end", i), n);
      tick(3);
      check($sformatf("vec%0d_writes", i), writes - w0, vecs[i].nwrites);
      check($sformatf("vec%0d_word", i), last_word, vecs[i].word);
      check($sformatf("vec%0d_rises", i), last_rises, 16);
      check($sformatf("vec%0d_tx", i), tx_enable, vecs[i].tx);
    end

    // ---- Reset in the middle of SHIFT ----
    band = 3'd1;
    wait_busy(1'b1, 20, "t6_start", n);
    tick(10);
    reset = 1'b1;
    tick(1);
    check("t6_reset_outputs", {relay_sclk, relay_sdo, relay_load, busy, tx_enable}, 5'b0);
    tick(1);
    reset = 1'b0;
    w0 = writes;
    wait_busy(1'b1, 20, "t6_restart", n);
    wait_busy(1'b0, 500, "t6_end", n);
    check("t6_busy_len", n, 76);
    tick(3);
    check("t6_writes", writes - w0, 1);
    check("t6_word", last_word, 16'h0102);
    check("t6_rises", last_rises, 16);
    check("t6_tx", tx_enable, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
